// File: rtl/mac_accumulate.sv
// Accumulate stage behind the 8x8 / dual 8x4 multiplier.
// Sums a window of products with saturation and hands the result downstream.
module mac_accumulate #(
    parameter int ACC_W   = 24,
    parameter int ACC_W_S = 16,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               split,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        prod,
    input  logic [11:0]        prod1,
    input  logic [11:0]        prod2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc,
    output logic [ACC_W_S-1:0] acc1,
    output logic [ACC_W_S-1:0] acc2,
    output logic               ovf,
    output logic               mode_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] count_nx;
    logic             fire;
    logic             first;
    logic             cur_mode;

    logic [ACC_W-1:0]   base_f;
    logic [ACC_W_S-1:0] base_1;
    logic [ACC_W_S-1:0] base_2;
    logic [ACC_W:0]     sum_f;
    logic [ACC_W_S:0]   sum_1;
    logic [ACC_W_S:0]   sum_2;
    logic [ACC_W-1:0]   sat_f;
    logic [ACC_W_S-1:0] sat_1;
    logic [ACC_W_S-1:0] sat_2;
    logic               of_f;
    logic               of_1;
    logic               of_2;
    logic               of_now;

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign fire      = in_valid && in_ready;
    assign first     = (state_q == IDLE);
    assign len_eff   = (len == '0) ? LEN_W'(1) : len;
    assign count_nx  = count_q + LEN_W'(1);
    assign cur_mode  = first ? split : mode_q;

    // The first beat of a window loads rather than adds, so start from zero.
    assign base_f = first ? '0 : acc;
    assign base_1 = first ? '0 : acc1;
    assign base_2 = first ? '0 : acc2;

    assign sum_f = {base_f[ACC_W-1], base_f}
                 + {{(ACC_W-15){prod[15]}}, prod};
    assign sum_1 = {base_1[ACC_W_S-1], base_1}
                 + {{(ACC_W_S-11){prod1[11]}}, prod1};
    assign sum_2 = {base_2[ACC_W_S-1], base_2}
                 + {{(ACC_W_S-11){prod2[11]}}, prod2};

    assign of_f = sum_f[ACC_W] != sum_f[ACC_W-1];
    assign of_1 = sum_1[ACC_W_S] != sum_1[ACC_W_S-1];
    assign of_2 = sum_2[ACC_W_S] != sum_2[ACC_W_S-1];

    // Clamp toward the sign of the wide result.
    assign sat_f = !of_f ? sum_f[ACC_W-1:0]
                 : sum_f[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                 : {1'b0, {(ACC_W-1){1'b1}}};
    assign sat_1 = !of_1 ? sum_1[ACC_W_S-1:0]
                 : sum_1[ACC_W_S] ? {1'b1, {(ACC_W_S-1){1'b0}}}
                 : {1'b0, {(ACC_W_S-1){1'b1}}};
    assign sat_2 = !of_2 ? sum_2[ACC_W_S-1:0]
                 : sum_2[ACC_W_S] ? {1'b1, {(ACC_W_S-1){1'b0}}}
                 : {1'b0, {(ACC_W_S-1){1'b1}}};

    assign of_now = cur_mode ? (of_1 || of_2) : of_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = (len_eff == LEN_W'(1)) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (fire && count_nx == len_q) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= 1'b0;
            len_q   <= '0;
            count_q <= '0;
            acc     <= '0;
            acc1    <= '0;
            acc2    <= '0;
            ovf     <= 1'b0;
        end else if (fire) begin
            if (first) begin
                mode_q  <= split;
                len_q   <= len_eff;
                count_q <= LEN_W'(1);
                ovf     <= of_now;
            end else begin
                count_q <= count_nx;
                ovf     <= ovf || of_now;
            end
            acc  <= cur_mode ? '0 : sat_f;
            acc1 <= cur_mode ? sat_1 : '0;
            acc2 <= cur_mode ? sat_2 : '0;
        end
    end

endmodule

// File: tb/tb_mac_accumulate.sv
// Directed bench for mac_accumulate.
// Inputs change and outputs are sampled on the falling edge.
module tb_mac_accumulate;

    localparam int ACC_W   = 18;
    localparam int ACC_W_S = 16;
    localparam int LEN_W   = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      split;
    logic [LEN_W-1:0]          len;
    logic                      in_valid;
    logic                      in_ready;
    logic [15:0]               prod;
    logic [11:0]               prod1;
    logic [11:0]               prod2;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W_S-1:0] acc1;
    logic signed [ACC_W_S-1:0] acc2;
    logic                      ovf;
    logic                      mode_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_accumulate #(
        .ACC_W  (ACC_W),
        .ACC_W_S(ACC_W_S),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .split    (split),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .prod     (prod),
        .prod1    (prod1),
        .prod2    (prod2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc      (acc),
        .acc1     (acc1),
        .acc2     (acc2),
        .ovf      (ovf),
        .mode_q   (mode_q)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input logic s, input int l, input int p,
                        input int p1, input int p2);
        split    = s;
        len      = l[LEN_W-1:0];
        prod     = p[15:0];
        prod1    = p1[11:0];
        prod2    = p2[11:0];
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, int'(in_ready), 1);
        check({tag, "_idle_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        rst       = 1'b1;
        split     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        prod      = '0;
        prod1     = '0;
        prod2     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_acc", int'(acc), 0);
        check("rst_ovf", int'(ovf), 0);

        // Full window of four beats
        beat(1'b0, 4, 100, 0, 0);
        beat(1'b0, 4, -50, 0, 0);
        beat(1'b0, 4, 16384, 0, 0);
        check("full_not_early", int'(out_valid), 0);
        beat(1'b0, 4, -16384, 0, 0);
        check("full_valid", int'(out_valid), 1);
        check("full_acc", int'(acc), 50);
        check("full_ovf", int'(ovf), 0);
        check("full_mode", int'(mode_q), 0);
        check("full_acc1", int'(acc1), 0);
        check("full_acc2", int'(acc2), 0);
        take("full");

        // Split window
        beat(1'b1, 3, 0, 1024, -1024);
        beat(1'b1, 3, 0, -7, 5);
        beat(1'b1, 3, 0, 3, 3);
        check("split_valid", int'(out_valid), 1);
        check("split_acc1", int'(acc1), 1020);
        check("split_acc2", int'(acc2), -1016);
        check("split_acc", int'(acc), 0);
        check("split_mode", int'(mode_q), 1);
        take("split");

        // Full-mode saturation, then a clean single-beat window
        for (int i = 0; i < 9; i++) beat(1'b0, 9, 16384, 0, 0);
        check("sat_valid", int'(out_valid), 1);
        check("sat_acc", int'(acc), 131071);
        check("sat_ovf", int'(ovf), 1);
        take("sat");
        beat(1'b0, 1, -5, 0, 0);
        check("after_sat_valid", int'(out_valid), 1);
        check("after_sat_acc", int'(acc), -5);
        check("after_sat_ovf", int'(ovf), 0);
        take("after_sat");

        // Split saturation with a bubble between beats
        for (int i = 0; i < 33; i++) begin
            if (i == 32) check("bub_not_early", int'(out_valid), 0);
            beat(1'b1, 33, 0, -1024, 1);
            if (i < 32) @(negedge clk);
        end
        check("bub_valid", int'(out_valid), 1);
        check("bub_acc1", int'(acc1), -32768);
        check("bub_acc2", int'(acc2), 33);
        check("bub_ovf", int'(ovf), 1);
        take("bub");

        // len=0 and backpressure
        beat(1'b0, 0, 7, 0, 0);
        check("len0_valid", int'(out_valid), 1);
        check("len0_acc", int'(acc), 7);
        prod     = 16'd99;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_acc", int'(acc), 7);
        end
        in_valid = 1'b0;
        take("bp");

        // split and len changes mid-window are ignored
        beat(1'b0, 3, 1, 0, 0);
        beat(1'b1, 1, 2, 50, 50);
        check("mid_not_early", int'(out_valid), 0);
        beat(1'b1, 2, 3, 50, 50);
        check("mid_valid", int'(out_valid), 1);
        check("mid_acc", int'(acc), 6);
        check("mid_mode", int'(mode_q), 0);
        check("mid_acc1", int'(acc1), 0);
        take("mid");

        // Reset in the middle of a window
        beat(1'b1, 4, 0, 9, 9);
        beat(1'b1, 4, 0, 9, 9);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mrst_in_ready", int'(in_ready), 1);
        check("mrst_out_valid", int'(out_valid), 0);
        check("mrst_acc1", int'(acc1), 0);
        check("mrst_acc2", int'(acc2), 0);
        check("mrst_mode", int'(mode_q), 0);
        check("mrst_ovf", int'(ovf), 0);
        beat(1'b0, 2, 5, 0, 0);
        beat(1'b0, 2, 6, 0, 0);
        check("fresh_valid", int'(out_valid), 1);
        check("fresh_acc", int'(acc), 11);
        take("fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_accumulate.md
Name: mac_accumulate

Overview:
- Accumulate stage placed directly after the 8x8 / dual 8x4 signed multiplier; consumes its full product S, or its two split products S1/S2.
- Sums a window of `len` products into saturating accumulators, one accumulator in 8x8 mode and two independent accumulators in split mode.
- Presents each window result with a valid/ready handshake to the conv output / requantise stage.

Parameters:
- ACC_W, 24, full-mode accumulator width in bits (must be ≥ 17).
- ACC_W_S, 16, width in bits of each split-mode accumulator (must be ≥ 13).
- LEN_W, 8, width of the window-length field.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- split  input  1  0 = accumulate prod; 1 = accumulate prod1/prod2 independently. Sampled on the first beat of a window.
- len  input  LEN_W  number of products in the window. Sampled on the first beat; 0 is treated as 1.
- in_valid  input  1  product beat valid.
- in_ready  output  1  stage can accept a beat.
- prod  input  16  signed two's-complement 8x8 product.
- prod1  input  12  signed 8x4 product, low nibble of B.
- prod2  input  12  signed 8x4 product, high nibble of B.
- out_valid  output  1  window result valid.
- out_ready  input  1  downstream accepts the result.
- acc  output  ACC_W  signed full-mode result; 0 in split mode.
- acc1  output  ACC_W_S  signed split result for prod1; 0 in full mode.
- acc2  output  ACC_W_S  signed split result for prod2; 0 in full mode.
- ovf  output  1  at least one saturation event occurred in this window.
- mode_q  output  1  split value latched for the presented window.

Behaviour:
- Reset values (all outputs):
  - in_ready=1, out_valid=0.
  - acc=acc1=acc2=0, ovf=0, mode_q=0.
  - FSM=IDLE, internal count=0.
- A beat is accepted when in_valid && in_ready. Product inputs are ignored on any other cycle.
- FSM IDLE (in_ready=1, out_valid=0), on an accepted beat:
  - Latch split into mode_q and latch max(len,1) into len_q.
  - Load the accumulators with the sign-extended product(s) and set count=1. The accumulator(s) of the unused mode load 0.
  - Clear ovf.
  - If len_q==1, go to HOLD; otherwise go to ACC.
- FSM ACC (in_ready=1), on each accepted beat:
  - acc += sext(prod), or acc1 += sext(prod1) and acc2 += sext(prod2).
  - count += 1.
  - When count reaches len_q with this beat, go to HOLD.
  - split and len changes during ACC are ignored.
- FSM HOLD (in_ready=0, out_valid=1):
  - acc, acc1, acc2, ovf and mode_q are stable.
  - On out_ready, go to IDLE: out_valid=0 and in_ready=1 in the next cycle.
  - No bypass: a new window cannot start in the same cycle the result is taken.
- Latency: out_valid rises the cycle after the last beat is accepted. Minimum window period is len_q+1 cycles.
- Arithmetic:
  - Each add is computed one bit wider than the accumulator.
  - If the result exceeds the signed max or min, the accumulator clamps to that bound and ovf sets sticky for the window.
  - Later beats continue to accumulate from the clamped value.
  - Split accumulators saturate independently; ovf is the OR of both.
- Bubbles (in_valid low) in ACC do not advance count.
- Reset at any point returns every register to its reset value; a partially accumulated window is discarded.
- out_ready while not in HOLD has no effect.

Test Plan:
- Full window: split=0, len=4, prod=100,−50,16384,−16384 back-to-back → out_valid exactly 1 cycle after beat 4, acc=50, ovf=0, mode_q=0, acc1=acc2=0.
- Split window: split=1, len=3, (prod1,prod2)=(1024,−1024),(−7,5),(3,3) → acc1=1020, acc2=−1016, acc=0, mode_q=1.
- Saturation: ACC_W=18, split=0, len=9, prod=16384 ×9 → acc=131071, ovf=1. Next window len=1, prod=−5 → acc=−5, ovf=0.
- Split saturation and bubbles: split=1, len=33, prod1=−1024 ×33, prod2=1 ×33, with in_valid low every other cycle:
  - acc1=−32768, acc2=33, ovf=1.
  - Result appears 1 cycle after the 33rd accepted beat.
- Backpressure, len=0, mid-window changes:
  - len=0, prod=7 → HOLD after 1 beat, acc=7.
  - Hold out_ready=0 for 3 cycles → out_valid and acc stable, in_ready=0, extra in_valid beats not accepted.
  - split/len toggled mid-window do not alter the result.
- Reset mid-operation: assert rst after 2 of 4 beats → next cycle all outputs at reset values. A fresh len=2 window of 5,6 → acc=11.
